acc_mem_arbiter: RTL



---
 rtl/acc_mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/acc_mem_arbiter.sv
// Data Memory arbiter: the CPU data port has fixed priority, and a starvation counter forces a slot for the accelerator.
// Granted CPU writes are mirrored onto the MMIO listen lines in the same cycle.
module acc_mem_arbiter #(
  parameter int ADDR_SIZE    = 16,
  parameter int WORD_SIZE    = 32,
  parameter int LINE_SIZE    = 512,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_grant,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_rdata_valid,
  input  logic                 acc_read_en,
  input  logic [ADDR_SIZE-1:0] acc_read_addr,
  output logic [LINE_SIZE-1:0] acc_read_data,
  output logic                 acc_read_data_valid,
  input  logic                 acc_write_en,
  input  logic [ADDR_SIZE-1:0] acc_write_addr,
  input  logic [WORD_SIZE-1:0] acc_write_data,
  output logic                 acc_write_done,
  output logic                 mem_listen_en,
  output logic [ADDR_SIZE-1:0] mem_listen_addr,
  output logic [WORD_SIZE-1:0] mem_listen_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [LINE_SIZE-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int IDX_W = $clog2(LINE_SIZE / WORD_SIZE);
  localparam int OFF_W = $clog2(WORD_SIZE / 8);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ACC_RD_RESP,
    ACC_WR_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             cpu_rd_pend_q, cpu_rd_pend_d;
  logic [IDX_W-1:0] cpu_idx_q, cpu_idx_d;

  logic acc_pend;
  logic acc_win;
  logic acc_rd_win;
  logic acc_wr_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      cpu_rd_pend_q <= 1'b0;
      cpu_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      cpu_rd_pend_q <= cpu_rd_pend_d;
      cpu_idx_q     <= cpu_idx_d;
    end
  end

  // Grants are held off while reset is asserted so that memory is never strobed during reset.
  always_comb begin
    acc_pend   = rst_n & (acc_read_en | acc_write_en) & (state_q == IDLE);
    acc_win    = acc_pend & (~cpu_req | (starve_cnt_q >= LIMIT));
    acc_rd_win = acc_win & acc_read_en;
    acc_wr_win = acc_win & ~acc_read_en;
    cpu_grant  = rst_n & cpu_req & ~acc_win;
  end

  always_comb begin
    state_d = IDLE;
    if (acc_rd_win) begin
      state_d = ACC_RD_RESP;
    end else if (acc_wr_win) begin
      state_d = ACC_WR_RESP;
    end

    starve_cnt_d = starve_cnt_q;
    if (acc_win) begin
      starve_cnt_d = '0;
    end else if (acc_pend && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    cpu_rd_pend_d = cpu_grant & ~cpu_we;
    cpu_idx_d     = cpu_idx_q;
    if (cpu_grant && !cpu_we) begin
      cpu_idx_d = cpu_addr[OFF_W +: IDX_W];
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc_rd_win) begin
      mem_en   = 1'b1;
      mem_addr = acc_read_addr;
    end else if (acc_wr_win) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = acc_write_addr;
      mem_wdata = acc_write_data;
    end else if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end

    mem_listen_en   = cpu_grant & cpu_we;
    mem_listen_addr = mem_listen_en ? cpu_addr : '0;
    mem_listen_data = mem_listen_en ? cpu_wdata : '0;

    acc_read_data_valid = (state_q == ACC_RD_RESP);
    acc_read_data       = acc_read_data_valid ? mem_rdata : '0;
    acc_write_done      = (state_q == ACC_WR_RESP);

    cpu_rdata_valid = cpu_rd_pend_q;
    cpu_rdata       = '0;
    if (cpu_rd_pend_q) begin
      cpu_rdata = mem_rdata[int'(cpu_idx_q) * WORD_SIZE +: WORD_SIZE];
    end
  end

endmodule
